ps2_kb_rx: RTL and testbench

Parametrised PS/2 keyboard receiver running entirely in the system clock domain. Oversamples the open-collector PS/2 clock and data lines, deframes 11-bit device-to-host frames, decodes make/break codes through a parametrised keymap into a held-key bitmap, and queues press/release events in a small FIFO for the CPU core. It is the input front end of the CHIP-8 core and adds a frame watchdog, explicit error reporting, event buffering and extended-code handling.

---
 rtl/ps2_kb_rx.sv | 153 +++++++++++++++
 tb/tb_ps2_kb_rx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ps2_kb_rx.sv
// ps2_kb_rx: PS/2 keyboard receiver with keymap decode, held-key bitmap and event FIFO.
// Define PS2_KB_EXT_EN to treat E0 as an extended-code prefix whose following code is swallowed.
module ps2_kb_rx #(
  parameter int NUM_KEYS = 16,
  parameter logic [8*NUM_KEYS-1:0] KEYMAP = 128'h2A2B2D251A21231B1C241D15261E1622,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 16384,
  localparam int KW = $clog2(NUM_KEYS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] input_keys,
  output logic [KW-1:0]       newest_key_down,
  input  logic                clear_newest_key_down,
  output logic                ev_valid,
  output logic [KW:0]         ev_data,
  input  logic                ev_ready,
  output logic                frame_error,
  output logic                ev_overflow
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;
  state_e state_q, state_d;
  logic [2:0] ck_q;
  logic [1:0] dt_q;
  logic [2:0] bc_q, bc_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d;
  logic [WW-1:0] wd_q;
  logic fall, bit_w, timeout, byte_ok, bad;
  logic hit, is_f0, is_e0, skip, act, held, make_new, brk, push_req;
  logic [KW-1:0] idx;
  logic [NUM_KEYS-1:0] oh, keys_q, keys_d;
  logic rel_q, rel_d;
  logic [KW-1:0] newest_q;
  logic [KW:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] fc_q;
  logic pop, push, full, ferr_q, ovf_q;
  assign fall = ck_q[2] & ~ck_q[1];
  assign bit_w = dt_q[1];
  assign timeout = (state_q != IDLE) && !fall && (wd_q == WW'(TIMEOUT_CYCLES - 2));
  always_comb begin
    state_d = state_q;
    bc_d = bc_q;
    sh_d = sh_q;
    par_d = par_q;
    byte_ok = 1'b0;
    bad = 1'b0;
    if (timeout) state_d = IDLE;
    else if (fall)
      case (state_q)
        IDLE: begin
          state_d = bit_w ? IDLE : DATA;
          bc_d = '0;
        end
        DATA: begin
          sh_d = {bit_w, sh_q[7:1]};
          bc_d = bc_q + 3'd1;
          state_d = (bc_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d = ^{sh_q, bit_w};
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          byte_ok = bit_w & par_q;
          bad = ~(bit_w & par_q);
        end
      endcase
  end
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (KEYMAP[8*i +: 8] == sh_q) begin
        hit = 1'b1;
        idx = KW'(i);
      end
  end
  assign is_f0 = sh_q == 8'hF0;
`ifdef PS2_KB_EXT_EN
  logic ext_q, ext_d;
  assign is_e0 = sh_q == 8'hE0;
  assign skip = ext_q;
  assign ext_d = (bad | timeout) ? 1'b0 : (byte_ok && !is_f0) ? is_e0 : ext_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ext_q <= 1'b0;
    else ext_q <= ext_d;
`else
  assign is_e0 = 1'b0;
  assign skip = 1'b0;
`endif
  assign oh = hit ? (NUM_KEYS'(1) << idx) : '0;
  assign held = |(keys_q & oh);
  assign act = byte_ok && !is_f0 && !is_e0 && hit && !skip;
  assign make_new = act && !rel_q && !held;
  assign brk = act && rel_q && held;
  assign push_req = make_new | brk;
  assign keys_d = make_new ? (keys_q | oh) : brk ? (keys_q & ~oh) : keys_q;
  assign rel_d = (bad | timeout) ? 1'b0 : byte_ok ? (is_f0 | (is_e0 & rel_q)) : rel_q;
  // Full FIFO still accepts a push when the head leaves in the same cycle.
  assign full = fc_q == (AW + 1)'(FIFO_DEPTH);
  assign pop = ev_valid && ev_ready;
  assign push = push_req && (!full || pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ck_q <= '1;
      dt_q <= '1;
      state_q <= IDLE;
      bc_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      wd_q <= '0;
      keys_q <= '0;
      rel_q <= 1'b0;
      newest_q <= KW'(NUM_KEYS);
      wp_q <= '0;
      rp_q <= '0;
      fc_q <= '0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ck_q <= {ck_q[1:0], ps2_clk};
      dt_q <= {dt_q[0], ps2_data};
      state_q <= state_d;
      bc_q <= bc_d;
      sh_q <= sh_d;
      par_q <= par_d;
      wd_q <= (fall || state_q == IDLE) ? '0 : wd_q + WW'(1);
      keys_q <= keys_d;
      rel_q <= rel_d;
      newest_q <= make_new ? idx : clear_newest_key_down ? KW'(NUM_KEYS) : newest_q;
      wp_q <= push ? wp_q + AW'(1) : wp_q;
      rp_q <= pop ? rp_q + AW'(1) : rp_q;
      fc_q <= fc_q + (AW + 1)'(push) - (AW + 1)'(pop);
      ferr_q <= bad | timeout;
      ovf_q <= ovf_q | (push_req & ~push);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    else if (push) mem_q[wp_q] <= {brk, idx};
  assign input_keys = keys_q;
  assign newest_key_down = newest_q;
  assign ev_valid = fc_q != '0;
  assign ev_data = mem_q[rp_q];
  assign frame_error = ferr_q;
  assign ev_overflow = ovf_q;
endmodule

// File: tb/tb_ps2_kb_rx.sv
// tb_ps2_kb_rx: directed PS/2 frames with an event scoreboard for ps2_kb_rx.
module tb_ps2_kb_rx;
  localparam int NK = 16;
  localparam int KW = 5;
  localparam int TO = 16384;
  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, clr = 0, ev_ready = 1;
  logic [NK-1:0] input_keys;
  logic [KW-1:0] newest;
  logic ev_valid, frame_error, ev_overflow;
  logic [KW:0] ev_data, e;
  logic [KW:0] exp_q[$];
  int checks = 0, errors = 0, err_cnt = 0, e0;
  ps2_kb_rx dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .input_keys(input_keys), .newest_key_down(newest),
    .clear_newest_key_down(clr), .ev_valid(ev_valid), .ev_data(ev_data),
    .ev_ready(ev_ready), .frame_error(frame_error), .ev_overflow(ev_overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_error) err_cnt++;
    if (ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected: got %h, required none", ev_data);
      end else begin
        e = exp_q.pop_front();
        if (ev_data !== e) begin
          errors++;
          $display("FAIL event_data: got %h, required %h", ev_data, e);
        end
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bit_out(input logic b, input bit clr_here = 0);
    ps2_data = b;
    wait_clk(4);
    ps2_clk = 0;
    if (clr_here) begin
      wait_clk(2);
      clr = 1;
      wait_clk(1);
      clr = 0;
      wait_clk(5);
    end else wait_clk(8);
    ps2_clk = 1;
    wait_clk(4);
  endtask
  task automatic send(input logic [7:0] b, input bit badpar = 0, input bit clr_stop = 0);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(~^b ^ badpar);
    bit_out(1'b1, clr_stop);
    wait_clk(4);
  endtask
  initial begin
    wait_clk(4);
    rst = 0;
    wait_clk(2);
    chk("rst_keys", int'(input_keys), 0);
    chk("rst_newest", int'(newest), NK);
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_data", int'(ev_data), 0);
    chk("rst_ferr", int'(frame_error), 0);
    chk("rst_ovf", int'(ev_overflow), 0);
    exp_q.push_back(6'h07);
    send(8'h1C);
    chk("make_keys", int'(input_keys), 16'h0080);
    chk("make_newest", int'(newest), 7);
    exp_q.push_back(6'h27);
    send(8'hF0);
    send(8'h1C);
    chk("break_keys", int'(input_keys), 0);
    chk("break_newest", int'(newest), 7);
    e0 = err_cnt;
    send(8'h1C, 1);
    chk("parity_err", err_cnt - e0, 1);
    chk("parity_keys", int'(input_keys), 0);
    exp_q.push_back(6'h07);
    send(8'h1C);
    chk("after_par_keys", int'(input_keys), 16'h0080);
    exp_q.push_back(6'h27);
    send(8'hF0);
    send(8'h1C);
    e0 = err_cnt;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(i == 1 || i == 2);
    wait_clk(TO + 50);
    chk("timeout_err", err_cnt - e0, 1);
    exp_q.push_back(6'h01);
    send(8'h16);
    chk("timeout_keys", int'(input_keys), 16'h0002);
    chk("timeout_newest", int'(newest), 1);
    exp_q.push_back(6'h02);
    send(8'h1E, 0, 1);
    chk("clr_same_newest", int'(newest), 2);
    clr = 1;
    wait_clk(1);
    clr = 0;
    wait_clk(1);
    chk("clr_lone_newest", int'(newest), NK);
    exp_q.push_back(6'h22);
    send(8'hF0);
    send(8'h1E);
    chk("rel2_keys", int'(input_keys), 16'h0002);
    ev_ready = 0;
    exp_q.push_back(6'h03);
    exp_q.push_back(6'h04);
    exp_q.push_back(6'h05);
    exp_q.push_back(6'h06);
    send(8'h26);
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    chk("full_ovf", int'(ev_overflow), 0);
    send(8'h1B);
    chk("ovf_set", int'(ev_overflow), 1);
    chk("ovf_keys", int'(input_keys), 16'h017A);
    chk("ovf_valid", int'(ev_valid), 1);
    ev_ready = 1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) wait_clk(1);
    chk("drain_left", exp_q.size(), 0);
    wait_clk(2);
    chk("drain_valid", int'(ev_valid), 0);
`ifdef PS2_KB_EXT_EN
    send(8'hE0);
    send(8'h1C);
    chk("ext_keys", int'(input_keys), 16'h017A);
`else
    exp_q.push_back(6'h07);
    send(8'hE0);
    send(8'h1C);
    chk("noext_keys", int'(input_keys), 16'h01FA);
`endif
    wait_clk(5);
    chk("events_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
